addr_wr_cal: RTL and testbench

Write-side address generator for the DDR3 ping-pong frame buffer. It accepts packed pixel words from the upstream packer, queues them in a small FIFO, and issues them to the DDR3 arbiter during the write slot of the 6-phase schedule (cnt_6 == 0). Each write carries a raster-order address inside the current page. When a page (one block row: 53 lines × 216 words) is complete, it toggles page_sel and moves to the other page. The block-wise read generator on the same schedule consumes page_sel.

---
 rtl/ddr_buf_pkg.sv | 20 ++
 rtl/addr_wr_cal_if.sv | 15 +
 rtl/wr_sync_fifo.sv | 58 +++++
 rtl/addr_wr_cal.sv | 112 +++++++++++
 tb/tb_addr_wr_cal.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_buf_pkg.sv
// Geometry and slot constants shared by the DDR3 frame-buffer write and read generators.
// Both pages are raster-contiguous: one block row of 53 lines x 216 words each.
package ddr_buf_pkg;

  typedef logic [15:0] ddr_addr_t;

  localparam ddr_addr_t PAGE_ONE       = 16'd1;
  localparam ddr_addr_t PAGE_TWO       = 16'd11449;
  localparam int        WORDS_PER_LINE = 216;
  localparam int        LINES_PER_PAGE = 53;
  localparam int        PAGE_WORDS     = WORDS_PER_LINE * LINES_PER_PAGE;
  localparam logic [2:0] WR_SLOT       = 3'd0;
  localparam logic [2:0] RD_SLOT       = 3'd3;

  // The writer fills the page the reader is not currently reading.
  function automatic ddr_addr_t wr_page_base(input logic page_sel);
    return page_sel ? PAGE_TWO : PAGE_ONE;
  endfunction

endpackage

// File: rtl/addr_wr_cal_if.sv
// Packed-word input stream from the packer plus the write strobe bus towards the DDR3 arbiter.
// slave = the address generator, master = the side feeding words and observing writes.
interface addr_wr_cal_if #(parameter int DW = 16);
  import ddr_buf_pkg::*;

  logic          din_vld;
  logic [DW-1:0] din;
  logic          wr_en;
  ddr_addr_t     wr_addr;
  logic [DW-1:0] wr_data;

  modport slave  (input  din_vld, din, output wr_en, wr_addr, wr_data);
  modport master (output din_vld, din, input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/wr_sync_fifo.sv
// Synchronous FIFO with flush; push into a full FIFO is ignored unless a pop frees a slot the same cycle.
// Read data is the head entry, valid whenever empty_o is low.
module wr_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          i_pix_clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] pop_dat_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_o && !flush_i;
  assign do_push   = push_i && (!full_o || do_pop) && !flush_i;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/addr_wr_cal.sv
// Write-side address generator: queues packed words and issues one raster-order DDR3 write per write slot.
// Flips page_sel at each completed page; a rising i_vs flushes the queue and restarts the current write page.
module addr_wr_cal
  import ddr_buf_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             i_pix_clk,
  input  logic             rst_n,
  input  logic [2:0]       cnt_6,
  input  logic             i_vs,
  addr_wr_cal_if.slave     bus,
  output logic             page_sel,
  output logic             page_done,
  output logic             ovf
);

  logic          vs_q;
  logic          vs_rise;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_dat;
  logic          issue, last_word, drop;

  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [5:0]    line_cnt_q, line_cnt_d;
  ddr_addr_t     addr_q, addr_d;
  logic          page_sel_q, page_sel_d;
  logic          wr_en_q, page_done_q, ovf_q;
  ddr_addr_t     wr_addr_q;
  logic [DW-1:0] wr_data_q;

  assign vs_rise   = i_vs && !vs_q;
  // Resync owns the cycle: no pop, no write, no counter advance.
  assign issue     = (cnt_6 == WR_SLOT) && !fifo_empty && !vs_rise;
  assign last_word = issue && (word_cnt_q == 8'(WORDS_PER_LINE - 1))
                           && (line_cnt_q == 6'(LINES_PER_PAGE - 1));
  assign drop      = bus.din_vld && fifo_full && !issue && !vs_rise;

  wr_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_pix_clk  (i_pix_clk),
    .rst_n      (rst_n),
    .push_i     (bus.din_vld),
    .push_dat_i (bus.din),
    .pop_i      (issue),
    .flush_i    (vs_rise),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    addr_d     = addr_q;
    page_sel_d = page_sel_q;
    if (vs_rise) begin
      word_cnt_d = '0;
      line_cnt_d = '0;
      addr_d     = wr_page_base(page_sel_q);
    end else if (last_word) begin
      word_cnt_d = '0;
      line_cnt_d = '0;
      page_sel_d = !page_sel_q;
      addr_d     = wr_page_base(!page_sel_q);
    end else if (issue) begin
      addr_d = addr_q + 16'd1;
      if (word_cnt_q == 8'(WORDS_PER_LINE - 1)) begin
        word_cnt_d = '0;
        line_cnt_d = line_cnt_q + 6'd1;
      end else begin
        word_cnt_d = word_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      addr_q      <= PAGE_ONE;
      page_sel_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= PAGE_ONE;
      wr_data_q   <= '0;
      page_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vs_q        <= i_vs;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      page_sel_q  <= page_sel_d;
      wr_en_q     <= issue;
      page_done_q <= last_word;
      ovf_q       <= ovf_q || drop;
      if (issue) begin
        wr_addr_q <= addr_q;
        wr_data_q <= fifo_dat;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign page_sel    = page_sel_q;
  assign page_done   = page_done_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_addr_wr_cal.sv
// Scoreboard bench: every accepted push queues its expected address/data/page flags; a monitor checks each wr_en.
module tb_addr_wr_cal;

  localparam int DW = 16;

  logic       i_pix_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic       i_vs      = 1'b0;
  logic [2:0] cnt_6     = 3'd0;
  logic       page_sel, page_done, ovf;

  addr_wr_cal_if #(.DW(DW)) bus ();

  addr_wr_cal #(.DW(DW), .FIFO_DEPTH(8)) dut (
    .i_pix_clk (i_pix_clk),
    .rst_n     (rst_n),
    .cnt_6     (cnt_6),
    .i_vs      (i_vs),
    .bus       (bus.slave),
    .page_sel  (page_sel),
    .page_done (page_done),
    .ovf       (ovf)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
    logic        sel;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          pd_seen = 0;
  int          mode = 0;      // 0: real 0..5 schedule, 1: fast 0/3 alternation, 2: slot 0 withheld
  int          seq = 0;
  int          m_word, m_line;
  logic [15:0] m_addr;
  logic        m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 0;
    m_line = 0;
    m_addr = 16'd1;
    m_sel  = 1'b0;
  endtask

  // Expected write for an accepted word, with the raster/page walk done by hand constants.
  task automatic record(input logic [15:0] d);
    exp_t e;
    e.addr = m_addr;
    e.data = d;
    e.done = 1'b0;
    if (m_word == 215 && m_line == 52) begin
      e.done = 1'b1;
      m_sel  = ~m_sel;
      m_word = 0;
      m_line = 0;
      m_addr = m_sel ? 16'd11449 : 16'd1;
    end else if (m_word == 215) begin
      m_word = 0;
      m_line++;
      m_addr++;
    end else begin
      m_word++;
      m_addr++;
    end
    e.sel = m_sel;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] next_data();
    seq++;
    return 16'(seq * 40503 + 7);
  endfunction

  task automatic push_word(input logic [15:0] d, input bit rec);
    @(negedge i_pix_clk);
    bus.din_vld = 1'b1;
    bus.din     = d;
    if (rec) record(d);
    @(negedge i_pix_clk);
    bus.din_vld = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      push_word(next_data(), 1'b1);
      repeat (gap) @(negedge i_pix_clk);
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge i_pix_clk);
      n++;
    end
    repeat (2) @(negedge i_pix_clk);
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},     bus.wr_en,   0);
    chk({tag, "_wr_addr"},   bus.wr_addr, 1);
    chk({tag, "_wr_data"},   bus.wr_data, 0);
    chk({tag, "_page_sel"},  page_sel,    0);
    chk({tag, "_page_done"}, page_done,   0);
    chk({tag, "_ovf"},       ovf,         0);
  endtask

  // Slot counter, updated just after each active edge.
  initial begin
    forever begin
      @(posedge i_pix_clk);
      #1;
      case (mode)
        1:       cnt_6 = (cnt_6 == 3'd0) ? 3'd3 : 3'd0;
        2:       cnt_6 = 3'd1;
        default: cnt_6 = (cnt_6 >= 3'd5) ? 3'd0 : cnt_6 + 3'd1;
      endcase
    end
  end

  // Monitor: compares every write strobe against the head of the scoreboard.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge i_pix_clk);
      if (bus.wr_en === 1'b1) begin
        chk("wr_en_gap", prev_en, 0);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr",   bus.wr_addr, e.addr);
          chk("wr_data",   bus.wr_data, e.data);
          chk("page_done", page_done,   e.done);
          chk("page_sel",  page_sel,    e.sel);
          if (page_done === 1'b1) pd_seen++;
        end
      end else if (page_done !== 1'b0) begin
        chk("page_done_idle", page_done, 0);
      end
      prev_en = (bus.wr_en === 1'b1);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.din_vld = 1'b0;
    bus.din     = '0;
    model_reset();
    repeat (3) @(negedge i_pix_clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Single word pushed in the cycle before slot 0: strobe two edges later.
    n = 0;
    @(negedge i_pix_clk);
    while (cnt_6 != 3'd5 && n < 12) begin
      @(negedge i_pix_clk);
      n++;
    end
    chk("slot5_found", cnt_6, 5);
    bus.din_vld = 1'b1;
    bus.din     = 16'hA5A5;
    record(16'hA5A5);
    @(negedge i_pix_clk);
    bus.din_vld = 1'b0;
    chk("single_lat1", bus.wr_en, 0);
    @(negedge i_pix_clk);
    chk("single_lat2", bus.wr_en, 1);
    wait_drain(20);

    // Overflow: ten back-to-back words with slot 0 withheld; only the first eight survive.
    mode = 2;
    repeat (3) @(negedge i_pix_clk);
    chk("ovf_before", ovf, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_pix_clk);
      bus.din_vld = 1'b1;
      bus.din     = next_data();
      if (i < 8) record(bus.din);
    end
    @(negedge i_pix_clk);
    bus.din_vld = 1'b0;
    @(negedge i_pix_clk);
    chk("ovf_set", ovf, 1);
    mode = 0;
    wait_drain(200);
    chk("ovf_sticky", ovf, 1);

    // Line wraps and the page-one flip at 11448, next word at 11449.
    mode = 1;
    feed(11449 - 9, 0);
    wait_drain(50);
    chk("flip1_page_sel", page_sel, 1);
    chk("flip1_count", pd_seen, 1);

    // Resync on page two: queued words are discarded, writing restarts at 11449.
    feed(500, 0);
    wait_drain(50);
    mode = 2;
    repeat (2) @(negedge i_pix_clk);
    for (int i = 0; i < 3; i++) push_word(next_data(), 1'b0);
    @(negedge i_pix_clk);
    i_vs = 1'b1;
    repeat (2) @(negedge i_pix_clk);
    i_vs   = 1'b0;
    m_word = 0;
    m_line = 0;
    m_addr = 16'd11449;
    mode   = 0;
    repeat (30) @(negedge i_pix_clk);
    chk("resync_page_sel", page_sel, 1);
    chk("resync_no_done", pd_seen, 1);
    feed(1, 4);
    wait_drain(100);

    // Finish page two (last address 22896) and flip back to page one at address 1.
    mode = 1;
    feed(11447, 0);
    feed(1, 0);
    wait_drain(50);
    chk("flip2_page_sel", page_sel, 0);
    chk("flip2_count", pd_seen, 2);

    // Reset mid-page aborts everything; writing restarts at address 1.
    feed(2999, 0);
    @(posedge i_pix_clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    model_reset();
    @(negedge i_pix_clk);
    chk_reset_vals("midrst");
    repeat (2) @(negedge i_pix_clk);
    rst_n = 1'b1;
    mode  = 0;
    feed(2, 4);
    wait_drain(100);
    chk("post_rst_page_sel", page_sel, 0);
    chk("post_rst_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
